// File: rtl/mem_pkg.sv
// Shared constants and request bundle for the dual-port memory
// request controller and its read trackers.
package mem_pkg;

   localparam int AW_DEF        = 16;
   localparam int DW_DEF        = 16;
   localparam int DEPTH_DEF     = 1024;
   localparam int STALL_MAX_DEF = 3;
   localparam int READ_LAT      = 2;

   typedef struct packed {
      logic              wr;
      logic [AW_DEF-1:0] addr;
      logic [DW_DEF-1:0] wdata;
   } memReq_t;

endpackage

// File: rtl/mem_rd_track.sv
// Per-channel read return: delays the read-issue flag by the memory
// latency and captures the memory output with a one-cycle valid strobe.
module mem_rd_track
   import mem_pkg::*;
#(
   parameter int DW = DW_DEF
) (
   input  logic          CLK,
   input  logic          Reset_N,
   input  logic          rdIssue,
   input  logic [DW-1:0] dataOut,
   output logic [DW-1:0] rData,
   output logic          rValid
);

   logic [READ_LAT-1:0] rdPipe;

   always_ff @(posedge CLK or negedge Reset_N) begin
      if (!Reset_N) begin
         rdPipe <= '0;
         rValid <= 1'b0;
         rData  <= '0;
      end else begin
         rdPipe <= {rdPipe[READ_LAT-2:0], rdIssue};
         rValid <= rdPipe[READ_LAT-1];
         if (rdPipe[READ_LAT-1]) begin
            rData <= dataOut;
         end
      end
   end

endmodule

// File: rtl/mem_port_ctrl.sv
// Two-channel request controller in front of the dual-port memory:
// range check, same-address arbitration, port registers, read return.
module mem_port_ctrl
   import mem_pkg::*;
#(
   parameter int AW        = AW_DEF,
   parameter int DW        = DW_DEF,
   parameter int DEPTH     = DEPTH_DEF,
   parameter int STALL_MAX = STALL_MAX_DEF
) (
   input  logic          CLK,
   input  logic          Reset_N,
   input  logic          Req_1,
   input  logic          Wr_1,
   input  logic [AW-1:0] Addr_1,
   input  logic [DW-1:0] WData_1,
   output logic          Ack_1,
   output logic [DW-1:0] RData_1,
   output logic          RValid_1,
   output logic          Err_1,
   output logic [AW-1:0] Address_1,
   output logic [DW-1:0] DataIn_1,
   output logic          WriteEna_1,
   output logic          ReadEna_1,
   input  logic [DW-1:0] DataOut_1,
   input  logic          Req_2,
   input  logic          Wr_2,
   input  logic [AW-1:0] Addr_2,
   input  logic [DW-1:0] WData_2,
   output logic          Ack_2,
   output logic [DW-1:0] RData_2,
   output logic          RValid_2,
   output logic          Err_2,
   output logic [AW-1:0] Address_2,
   output logic [DW-1:0] DataIn_2,
   output logic          WriteEna_2,
   output logic          ReadEna_2,
   input  logic [DW-1:0] DataOut_2
);

   localparam int LCW = (STALL_MAX < 4) ? 2 : $clog2(STALL_MAX + 1);
   localparam logic [LCW-1:0] SMAX  = LCW'(STALL_MAX);
   localparam logic [AW:0]    LIMIT = (AW+1)'(DEPTH);

   memReq_t        req1, req2;
   logic [LCW-1:0] loseCnt;
   logic           inRange1, inRange2;
   logic           collide, ch2Wins;
   logic           issue1, issue2;

   assign req1 = '{wr: Wr_1, addr: Addr_1, wdata: WData_1};
   assign req2 = '{wr: Wr_2, addr: Addr_2, wdata: WData_2};

   assign inRange1 = {1'b0, req1.addr} < LIMIT;
   assign inRange2 = {1'b0, req2.addr} < LIMIT;

   // Out-of-range requests are acked and dropped, so they never collide.
   assign collide = Req_1 & Req_2 & inRange1 & inRange2
                  & (req1.addr == req2.addr)
                  & (req1.wr | req2.wr);
   assign ch2Wins = collide & (loseCnt < SMAX);

   assign Ack_1 = Reset_N & Req_1 & ~ch2Wins;
   assign Ack_2 = Reset_N & Req_2 & ~(collide & ~ch2Wins);

   assign issue1 = Ack_1 & inRange1;
   assign issue2 = Ack_2 & inRange2;

   always_ff @(posedge CLK or negedge Reset_N) begin
      if (!Reset_N) begin
         loseCnt <= '0;
      end else if (Ack_1) begin
         loseCnt <= '0;
      end else if (ch2Wins) begin
         loseCnt <= loseCnt + 1'b1;
      end
   end

   always_ff @(posedge CLK or negedge Reset_N) begin
      if (!Reset_N) begin
         Address_1  <= '0;
         DataIn_1   <= '0;
         WriteEna_1 <= 1'b0;
         ReadEna_1  <= 1'b0;
         Err_1      <= 1'b0;
      end else begin
         WriteEna_1 <= issue1 & req1.wr;
         ReadEna_1  <= issue1 & ~req1.wr;
         Err_1      <= Ack_1 & ~inRange1;
         if (issue1) begin
            Address_1 <= req1.addr;
         end
         if (issue1 & req1.wr) begin
            DataIn_1 <= req1.wdata;
         end
      end
   end

   always_ff @(posedge CLK or negedge Reset_N) begin
      if (!Reset_N) begin
         Address_2  <= '0;
         DataIn_2   <= '0;
         WriteEna_2 <= 1'b0;
         ReadEna_2  <= 1'b0;
         Err_2      <= 1'b0;
      end else begin
         WriteEna_2 <= issue2 & req2.wr;
         ReadEna_2  <= issue2 & ~req2.wr;
         Err_2      <= Ack_2 & ~inRange2;
         if (issue2) begin
            Address_2 <= req2.addr;
         end
         if (issue2 & req2.wr) begin
            DataIn_2 <= req2.wdata;
         end
      end
   end

   mem_rd_track #(.DW(DW)) uTrack1 (
      .CLK     (CLK),
      .Reset_N (Reset_N),
      .rdIssue (issue1 & ~req1.wr),
      .dataOut (DataOut_1),
      .rData   (RData_1),
      .rValid  (RValid_1)
   );

   mem_rd_track #(.DW(DW)) uTrack2 (
      .CLK     (CLK),
      .Reset_N (Reset_N),
      .rdIssue (issue2 & ~req2.wr),
      .dataOut (DataOut_2),
      .rData   (RData_2),
      .rValid  (RValid_2)
   );

endmodule
